// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, saturating ALU / address generation,
// Z/V/N flag register and the EX/MEM pipeline register with stall/flush.
module ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [7:0]    imm,
  input  logic [DW-1:0] pc_plus2,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [DW-1:0] wb_data,
  input  logic          rf_write,
  input  logic          dm_write,
  input  logic          memtoreg,
  input  logic          mem_fwd_in,
  input  logic [2:0]    branch,
  input  logic [RW-1:0] rf_read_reg1,
  input  logic [RW-1:0] rf_read_reg2,
  input  logic [RW-1:0] rf_write_reg,
  output logic          rf_write_out,
  output logic          dm_write_out,
  output logic          memtoreg_out,
  output logic          mux,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] rf_data_out2,
  output logic [RW-1:0] rf_read_reg1_out,
  output logic [RW-1:0] rf_read_reg2_out,
  output logic [RW-1:0] rf_write_reg_out,
  output logic [2:0]    branch_out,
  output logic [2:0]    flags
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_RSVC = 4'hC, OP_RSVD = 4'hD, OP_PCS = 4'hE, OP_RSVF = 4'hF
  } op_e;

  op_e          op;
  logic [15:0]  a, b, alu, add_raw, sub_raw, psb;
  logic [31:0]  rot;
  logic [7:0]   red8;
  logic [4:0]   nib;
  logic [3:0]   sh;
  logic         add_ovf, sub_ovf, v_new, upd_z, upd_vn;

  always_comb begin
    case (fwd_a)
      2'd1:    a = result_out;
      2'd2:    a = wb_data;
      default: a = rs_data;
    endcase
    case (fwd_b)
      2'd1:    b = result_out;
      2'd2:    b = wb_data;
      default: b = rt_data;
    endcase
  end

  // Overflow only when operand signs make it possible; the clamp direction
  // always follows the sign of A for both add and subtract.
  assign add_raw = a + b;
  assign sub_raw = a - b;
  assign add_ovf = (a[15] == b[15]) && (add_raw[15] != a[15]);
  assign sub_ovf = (a[15] != b[15]) && (sub_raw[15] != a[15]);
  assign sh      = imm[3:0];
  assign red8    = a[15:8] + b[15:8] + a[7:0] + b[7:0];
  assign rot     = {a, a} >> sh;

  always_comb begin
    psb = '0;
    nib = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      nib = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
      psb[4*i +: 4] = (nib[4] != nib[3]) ? (nib[4] ? 4'h8 : 4'h7) : nib[3:0];
    end
  end

  always_comb begin
    op     = op_e'(opcode);
    alu    = '0;
    v_new  = 1'b0;
    upd_z  = 1'b0;
    upd_vn = 1'b0;
    case (op)
      OP_ADD: begin
        alu    = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : add_raw;
        v_new  = add_ovf;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_SUB: begin
        alu    = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sub_raw;
        v_new  = sub_ovf;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_XOR:    begin alu = a ^ b;              upd_z = 1'b1; end
      OP_RED:    alu = {{8{red8[7]}}, red8};
      OP_SLL:    begin alu = a << sh;            upd_z = 1'b1; end
      OP_SRA:    begin alu = $signed(a) >>> sh;  upd_z = 1'b1; end
      OP_ROR:    begin alu = rot[15:0];          upd_z = 1'b1; end
      OP_PADDSB: alu = psb;
      OP_LW, OP_SW: alu = (a & 16'hFFFE) + {{11{imm[3]}}, imm[3:0], 1'b0};
      OP_LLB:    alu = (a & 16'hFF00) | {8'h00, imm};
      OP_LHB:    alu = (a & 16'h00FF) | {imm, 8'h00};
      OP_PCS:    alu = pc_plus2;
      default:   alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_out     <= 1'b0;
      dm_write_out     <= 1'b0;
      memtoreg_out     <= 1'b0;
      mux              <= 1'b0;
      result_out       <= '0;
      rf_data_out2     <= '0;
      rf_read_reg1_out <= '0;
      rf_read_reg2_out <= '0;
      rf_write_reg_out <= '0;
      branch_out       <= '0;
      flags            <= '0;
    end else if (flush) begin
      rf_write_out     <= 1'b0;
      dm_write_out     <= 1'b0;
      memtoreg_out     <= 1'b0;
      mux              <= 1'b0;
      result_out       <= '0;
      rf_data_out2     <= '0;
      rf_read_reg1_out <= '0;
      rf_read_reg2_out <= '0;
      rf_write_reg_out <= '0;
      branch_out       <= '0;
    end else if (!stall) begin
      rf_write_out     <= rf_write;
      dm_write_out     <= dm_write;
      memtoreg_out     <= memtoreg;
      mux              <= mem_fwd_in;
      result_out       <= alu;
      rf_data_out2     <= b;
      rf_read_reg1_out <= rf_read_reg1;
      rf_read_reg2_out <= rf_read_reg2;
      rf_write_reg_out <= rf_write_reg;
      branch_out       <= branch;
      if (upd_z) flags[2] <= (alu == '0);
      if (upd_vn) begin
        flags[1] <= v_new;
        flags[0] <= alu[15];
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes model predictions, a monitor
// pops one prediction per clock and compares it with the EX/MEM outputs.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [3:0]  opcode;
  logic [15:0] rs_data, rt_data, pc_plus2, wb_data;
  logic [7:0]  imm;
  logic [1:0]  fwd_a, fwd_b;
  logic        rf_write, dm_write, memtoreg, mem_fwd_in;
  logic [2:0]  branch;
  logic [3:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic        rf_write_out, dm_write_out, memtoreg_out, mux;
  logic [15:0] result_out, rf_data_out2;
  logic [3:0]  rf_read_reg1_out, rf_read_reg2_out, rf_write_reg_out;
  logic [2:0]  branch_out, flags;

  ex_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .opcode(opcode),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc_plus2(pc_plus2),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .rf_write(rf_write),
    .dm_write(dm_write), .memtoreg(memtoreg), .mem_fwd_in(mem_fwd_in),
    .branch(branch), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_write_reg(rf_write_reg), .rf_write_out(rf_write_out),
    .dm_write_out(dm_write_out), .memtoreg_out(memtoreg_out), .mux(mux),
    .result_out(result_out), .rf_data_out2(rf_data_out2),
    .rf_read_reg1_out(rf_read_reg1_out), .rf_read_reg2_out(rf_read_reg2_out),
    .rf_write_reg_out(rf_write_reg_out), .branch_out(branch_out), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [15:0] d2;
    logic [18:0] ctrl;
    logic [2:0]  fl;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] m_res = '0, m_d2 = '0;
  logic [18:0] m_ctrl = '0;
  logic [2:0]  m_fl = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ctrl_now();
    return {rf_write_out, dm_write_out, memtoreg_out, mux, branch_out,
            rf_read_reg1_out, rf_read_reg2_out, rf_write_reg_out};
  endfunction

  // Reference ALU written from the arithmetic definitions with integers.
  task automatic alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] im, input logic [15:0] pc,
                           output logic [15:0] r, output bit uz, output bit uvn, output bit ov);
    int s, sa, sb2, x, y, off, sh;
    sa = $signed(a);
    sb2 = $signed(b);
    sh = int'(im[3:0]);
    r = '0; uz = 0; uvn = 0; ov = 0;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sa + sb2 : sa - sb2;
        ov = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = s[15:0]; uz = 1; uvn = 1;
      end
      4'h2: begin r = a ^ b; uz = 1; end
      4'h3: begin
        s = int'(a[15:8]) + int'(b[15:8]) + int'(a[7:0]) + int'(b[7:0]);
        s = s % 256;
        if (s >= 128) s = s - 256;
        r = s[15:0];
      end
      4'h4: begin s = int'(a) * (1 << sh); r = s[15:0]; uz = 1; end
      4'h5: begin s = sa >>> sh; r = s[15:0]; uz = 1; end
      4'h6: begin r = a; for (int j = 0; j < sh; j++) r = {r[0], r[15:1]}; uz = 1; end
      4'h7: begin
        for (int k = 0; k < 4; k++) begin
          x = int'(a[4*k +: 4]); if (x >= 8) x = x - 16;
          y = int'(b[4*k +: 4]); if (y >= 8) y = y - 16;
          s = x + y;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*k +: 4] = s[3:0];
        end
      end
      4'h8, 4'h9: begin
        off = int'(im[3:0]); if (off >= 8) off = off - 16;
        s = int'(a & 16'hFFFE) + 2 * off;
        r = s[15:0];
      end
      4'hA: r = (a & 16'hFF00) | {8'h00, im};
      4'hB: r = (a & 16'h00FF) | {im, 8'h00};
      4'hE: r = pc;
      default: r = '0;
    endcase
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [7:0] im, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic fl);
    logic [15:0] a, b, r;
    bit uz, uvn, ov;
    @(negedge clk);
    opcode = op; rs_data = rs; rt_data = rt; imm = im; fwd_a = fa; fwd_b = fb;
    stall = st; flush = fl;
    pc_plus2 = 16'($urandom); wb_data = 16'($urandom);
    rf_write = 1'($urandom); dm_write = 1'($urandom); memtoreg = 1'($urandom);
    mem_fwd_in = 1'($urandom); branch = 3'($urandom);
    rf_read_reg1 = 4'($urandom); rf_read_reg2 = 4'($urandom); rf_write_reg = 4'($urandom);
    a = (fa == 2'd1) ? m_res : (fa == 2'd2) ? wb_data : rs;
    b = (fb == 2'd1) ? m_res : (fb == 2'd2) ? wb_data : rt;
    if (fl) begin
      m_res = '0; m_d2 = '0; m_ctrl = '0;
    end else if (!st) begin
      alu_model(op, a, b, im, pc_plus2, r, uz, uvn, ov);
      m_res = r; m_d2 = b;
      m_ctrl = {rf_write, dm_write, memtoreg, mem_fwd_in, branch,
                rf_read_reg1, rf_read_reg2, rf_write_reg};
      if (uz) m_fl[2] = (r == 16'h0000);
      if (uvn) begin m_fl[1] = ov; m_fl[0] = r[15]; end
    end
    sb.push_back('{res: m_res, d2: m_d2, ctrl: m_ctrl, fl: m_fl});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_result"}, 32'(result_out), 32'h0);
    chk({tag, "_d2"}, 32'(rf_data_out2), 32'h0);
    chk({tag, "_ctrl"}, 32'(ctrl_now()), 32'h0);
    chk({tag, "_flags"}, 32'(flags), 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result_out", 32'(result_out), 32'(e.res));
        chk("rf_data_out2", 32'(rf_data_out2), 32'(e.d2));
        chk("ctrl", 32'(ctrl_now()), 32'(e.ctrl));
        chk("flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0; stall = 1'b0; flush = 1'b0; opcode = '0; rs_data = '0; rt_data = '0;
    imm = '0; pc_plus2 = '0; wb_data = '0; fwd_a = '0; fwd_b = '0; rf_write = 1'b0;
    dm_write = 1'b0; memtoreg = 1'b0; mem_fwd_in = 1'b0; branch = '0;
    rf_read_reg1 = '0; rf_read_reg2 = '0; rf_write_reg = '0;
    #22;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    drive(4'h0, 16'h7FF0, 16'h0020, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);  // 7FFF, V=1
    drive(4'h1, 16'h0005, 16'h0005, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);  // 0, Z=1
    drive(4'h2, 16'h00F0, 16'h000F, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);  // Z=0
    drive(4'h0, 16'h1234, 16'h0000, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(4'h0, 16'hDEAD, 16'h0001, 8'h00, 2'd1, 2'd0, 1'b0, 1'b0);  // 1235
    drive(4'h8, 16'h0003, 16'h5555, 8'h0F, 2'd0, 2'd0, 1'b0, 1'b0);  // 0000
    drive(4'hB, 16'h1234, 16'h0000, 8'hAB, 2'd0, 2'd0, 1'b0, 1'b0);  // AB34
    drive(4'h1, 16'h8000, 16'h0001, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);  // 8000, V=1 N=1
    drive(4'h7, 16'h7788, 16'h1188, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(4'h6, 16'h8001, 16'h0000, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);  // shift 0
    drive(4'h5, 16'h8001, 16'h0000, 8'h0F, 2'd0, 2'd0, 1'b0, 1'b0);
    drive(4'h3, 16'h7F7F, 16'h0102, 8'h00, 2'd0, 2'd2, 1'b0, 1'b0);
    drive(4'hE, 16'h0000, 16'h0000, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(4'h0, 16'($urandom), 16'($urandom), 8'($urandom), 2'd0, 2'd0, 1'b1, 1'b0);
    drive(4'h0, 16'h0001, 16'h0001, 8'h00, 2'd0, 2'd0, 1'b1, 1'b1);
    drive(4'h1, 16'h0001, 16'h0001, 8'h00, 2'd1, 2'd1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      drive(4'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
            2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));

    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("midreset");
    m_res = '0; m_d2 = '0; m_ctrl = '0; m_fl = '0;
    rst = 1'b1;

    for (int i = 0; i < 60; i++)
      drive(4'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
            2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      nmis++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
